// File: rtl/simple_arch_pkg.sv
// Shared constants, instruction field positions and fetch FSM states.
// HALT_DETECT_EN adds the HALT state to the state enum.
package simple_arch_pkg;

   localparam int unsigned XLEN   = 16;
   localparam int unsigned OPC_HI = 15;
   localparam int unsigned OPC_LO = 14;
   localparam int unsigned FN_HI  = 7;
   localparam int unsigned FN_LO  = 4;

   localparam logic [1:0]      OPC_HLT = 2'b11;
   localparam logic [3:0]      FN_HLT  = 4'b1111;
   // Function field 4'b1110: decoder does no register write and no forwarding match.
   localparam logic [XLEN-1:0] NOP     = 16'hC0E0;

   typedef enum logic [2:0] {
      S_FETCH = 3'd0,
      S_WAIT  = 3'd1,
      S_ISSUE = 3'd2,
`ifdef HALT_DETECT_EN
      S_DROP  = 3'd3,
      S_HALT  = 3'd4
`else
      S_DROP  = 3'd3
`endif
   } fetch_state_t;

   function automatic logic is_hlt(input logic [XLEN-1:0] insn);
      return (insn[OPC_HI:OPC_LO] == OPC_HLT) && (insn[FN_HI:FN_LO] == FN_HLT);
   endfunction

endpackage

// File: rtl/cmd_history.sv
// Three-deep issued-instruction history; flush inserts NOP at the head while still shifting.
module cmd_history
   import simple_arch_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            shift,
   input  logic            flush,
   input  logic [XLEN-1:0] din,
   output logic [XLEN-1:0] o_cmd,
   output logic [XLEN-1:0] o_before,
   output logic [XLEN-1:0] o_two_before
);

   logic [XLEN-1:0] r_cmd;
   logic [XLEN-1:0] r_before;
   logic [XLEN-1:0] r_two_before;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cmd        <= NOP;
         r_before     <= NOP;
         r_two_before <= NOP;
      end else if (shift || flush) begin
         r_cmd        <= flush ? NOP : din;
         r_before     <= r_cmd;
         r_two_before <= r_before;
      end
   end

   assign o_cmd        = r_cmd;
   assign o_before     = r_before;
   assign o_two_before = r_two_before;

endmodule

// File: rtl/fetch_issue_unit.sv
// Instruction fetch/issue FSM with redirect, stall and optional halt (HALT_DETECT_EN).
//
// state   | meaning
// S_FETCH | request pc from imem (req low only in the first cycle after reset)
// S_WAIT  | request outstanding, waiting for imem_ack
// S_ISSUE | command presented downstream, held while stall
// S_DROP  | redirected with request in flight; swallow its ack
// S_HALT  | HLT issued, everything frozen until reset
module fetch_issue_unit
   import simple_arch_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_data,
   input  logic            pc_load,
   input  logic [XLEN-1:0] branch_target,
   input  logic            stall,
   output logic [XLEN-1:0] command,
   output logic [XLEN-1:0] before_command,
   output logic [XLEN-1:0] two_before_command,
   output logic            cmd_valid,
   output logic [XLEN-1:0] pc_out,
   output logic            halted
);

   fetch_state_t    r_state;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_pc_out;
   logic            r_req;
   logic            r_valid;
   logic            w_ack_take;
   logic            w_run;
   logic            w_shift;
   logic            w_flush;
   logic [XLEN-1:0] w_cmd;

`ifdef HALT_DETECT_EN
   logic r_halted;
   assign w_run  = (r_state != S_HALT);
   assign halted = r_halted;
`else
   assign w_run  = 1'b1;
   assign halted = 1'b0;
`endif

   assign w_ack_take = r_req && imem_ack && ((r_state == S_FETCH) || (r_state == S_WAIT));

   always_comb begin
      w_shift = 1'b0;
      w_flush = 1'b0;
      if (w_run) begin
         if (pc_load)
            w_flush = 1'b1;
         else if (w_ack_take)
            w_shift = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_FETCH;
         r_pc     <= '0;
         r_pc_out <= '0;
         r_req    <= 1'b0;
         r_valid  <= 1'b0;
`ifdef HALT_DETECT_EN
         r_halted <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_FETCH, S_WAIT: begin
               if (pc_load) begin
                  r_pc    <= branch_target;
                  r_valid <= 1'b0;
                  // A request still in flight must have its ack swallowed.
                  if (r_req && !imem_ack) begin
                     r_state <= S_DROP;
                     r_req   <= 1'b0;
                  end else begin
                     r_state <= S_FETCH;
                     r_req   <= 1'b1;
                  end
               end else if (w_ack_take) begin
                  r_pc_out <= r_pc;
                  r_pc     <= r_pc + 16'd1;
                  r_valid  <= 1'b1;
                  r_state  <= S_ISSUE;
                  r_req    <= 1'b0;
               end else begin
                  r_state <= S_WAIT;
                  r_req   <= 1'b1;
               end
            end
            S_ISSUE: begin
               if (pc_load) begin
                  r_pc    <= branch_target;
                  r_valid <= 1'b0;
                  r_state <= S_FETCH;
                  r_req   <= 1'b1;
               end else if (!stall) begin
                  r_valid <= 1'b0;
`ifdef HALT_DETECT_EN
                  if (is_hlt(w_cmd)) begin
                     r_state  <= S_HALT;
                     r_req    <= 1'b0;
                     r_halted <= 1'b1;
                  end else begin
                     r_state <= S_FETCH;
                     r_req   <= 1'b1;
                  end
`else
                  r_state <= S_FETCH;
                  r_req   <= 1'b1;
`endif
               end
            end
            S_DROP: begin
               if (pc_load) begin
                  r_pc    <= branch_target;
                  r_valid <= 1'b0;
               end
               if (imem_ack) begin
                  r_state <= S_FETCH;
                  r_req   <= 1'b1;
               end
            end
`ifdef HALT_DETECT_EN
            S_HALT: begin
               r_req <= 1'b0;
            end
`endif
            default: begin
               r_state <= S_FETCH;
               r_req   <= 1'b0;
            end
         endcase
      end
   end

   cmd_history u_hist (
      .clk          (clk),
      .reset        (reset),
      .shift        (w_shift),
      .flush        (w_flush),
      .din          (imem_data),
      .o_cmd        (w_cmd),
      .o_before     (before_command),
      .o_two_before (two_before_command)
   );

   assign command   = w_cmd;
   assign imem_req  = r_req;
   assign imem_addr = r_pc;
   assign cmd_valid = r_valid;
   assign pc_out    = r_pc_out;

endmodule

// File: tb/tb_fetch_issue_unit.sv
// Directed bench for fetch_issue_unit; inputs driven and outputs sampled on the falling edge.
module tb_fetch_issue_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_data;
   logic        pc_load;
   logic [15:0] branch_target;
   logic        stall;
   logic [15:0] command;
   logic [15:0] before_command;
   logic [15:0] two_before_command;
   logic        cmd_valid;
   logic [15:0] pc_out;
   logic        halted;

   int n_total = 0;
   int n_bad   = 0;

   fetch_issue_unit dut (
      .clk                (clk),
      .reset              (reset),
      .imem_req           (imem_req),
      .imem_addr          (imem_addr),
      .imem_ack           (imem_ack),
      .imem_data          (imem_data),
      .pc_load            (pc_load),
      .branch_target      (branch_target),
      .stall              (stall),
      .command            (command),
      .before_command     (before_command),
      .two_before_command (two_before_command),
      .cmd_valid          (cmd_valid),
      .pc_out             (pc_out),
      .halted             (halted)
   );

   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic wait_req();
      int n = 0;
      while (!imem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk_eq("req_seen", 16'(imem_req), 16'd1);
   endtask

   task automatic fetch(input logic [15:0] d, input int lat);
      wait_req();
      repeat (lat) @(negedge clk);
      imem_ack  = 1'b1;
      imem_data = d;
      @(negedge clk);
      imem_ack  = 1'b0;
   endtask

   task automatic chk_reset_state(input string tag);
      chk_eq({tag, "_req"},    16'(imem_req),  16'd0);
      chk_eq({tag, "_addr"},   imem_addr,      16'h0000);
      chk_eq({tag, "_pcout"},  pc_out,         16'h0000);
      chk_eq({tag, "_cmd"},    command,        16'hC0E0);
      chk_eq({tag, "_bef"},    before_command, 16'hC0E0);
      chk_eq({tag, "_two"},    two_before_command, 16'hC0E0);
      chk_eq({tag, "_valid"},  16'(cmd_valid), 16'd0);
      chk_eq({tag, "_halted"}, 16'(halted),    16'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; imem_ack = 1'b0; imem_data = 16'h0000;
      pc_load = 1'b0; branch_target = 16'h0000; stall = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset_state("rst");

      // Ack in the first cycle after reset must be ignored.
      reset = 1'b0; imem_ack = 1'b1; imem_data = 16'h1234;
      @(negedge clk);
      imem_ack = 1'b0;
      chk_eq("post_rst_req",  16'(imem_req), 16'd1);
      chk_eq("post_rst_addr", imem_addr,     16'h0000);
      chk_eq("post_rst_cmd",  command,       16'hC0E0);
      chk_eq("post_rst_val",  16'(cmd_valid), 16'd0);

      fetch(16'h8101, 1);
      chk_eq("i1_cmd",   command,        16'h8101);
      chk_eq("i1_pcout", pc_out,         16'h0000);
      chk_eq("i1_valid", 16'(cmd_valid), 16'd1);
      chk_eq("i1_req",   16'(imem_req),  16'd0);
      chk_eq("i1_bef",   before_command, 16'hC0E0);

      fetch(16'h8202, 1);
      chk_eq("i2_cmd",   command,            16'h8202);
      chk_eq("i2_bef",   before_command,     16'h8101);
      chk_eq("i2_two",   two_before_command, 16'hC0E0);
      chk_eq("i2_pcout", pc_out,             16'h0001);

      // Stall for three cycles during issue.
      fetch(16'hC120, 0);
      chk_eq("i3_cmd", command, 16'hC120);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_eq("stl_cmd",   command,        16'hC120);
         chk_eq("stl_valid", 16'(cmd_valid), 16'd1);
         chk_eq("stl_req",   16'(imem_req),  16'd0);
         chk_eq("stl_pc",    imem_addr,      16'h0003);
         chk_eq("stl_pcout", pc_out,         16'h0002);
      end
      stall = 1'b0;
      @(negedge clk);
      chk_eq("stl_next_req",  16'(imem_req), 16'd1);
      chk_eq("stl_next_addr", imem_addr,     16'h0003);

      // Redirect while waiting; the late ack is discarded.
      @(negedge clk);
      chk_eq("w_req", 16'(imem_req), 16'd1);
      pc_load = 1'b1; branch_target = 16'h0040;
      @(negedge clk);
      pc_load = 1'b0;
      chk_eq("drop_req",   16'(imem_req),  16'd0);
      chk_eq("drop_cmd",   command,        16'hC0E0);
      chk_eq("drop_valid", 16'(cmd_valid), 16'd0);
      chk_eq("drop_bef",   before_command, 16'hC120);
      @(negedge clk);
      chk_eq("drop2_cmd", command, 16'hC0E0);
      imem_ack = 1'b1; imem_data = 16'hDEAD;
      @(negedge clk);
      imem_ack = 1'b0;
      chk_eq("refetch_req",   16'(imem_req),  16'd1);
      chk_eq("refetch_addr",  imem_addr,      16'h0040);
      chk_eq("refetch_cmd",   command,        16'hC0E0);
      chk_eq("refetch_valid", 16'(cmd_valid), 16'd0);
      fetch(16'h9999, 0);
      chk_eq("i4_cmd",   command,            16'h9999);
      chk_eq("i4_pcout", pc_out,             16'h0040);
      chk_eq("i4_bef",   before_command,     16'hC0E0);
      chk_eq("i4_two",   two_before_command, 16'hC120);

      // Redirect beats stall in issue; target also exercises pc wrap.
      stall = 1'b1; pc_load = 1'b1; branch_target = 16'hFFFF;
      @(negedge clk);
      stall = 1'b0; pc_load = 1'b0;
      chk_eq("rs_cmd",   command,        16'hC0E0);
      chk_eq("rs_valid", 16'(cmd_valid), 16'd0);
      chk_eq("rs_req",   16'(imem_req),  16'd1);
      chk_eq("rs_addr",  imem_addr,      16'hFFFF);
      chk_eq("rs_bef",   before_command, 16'h9999);
      fetch(16'h1111, 0);
      chk_eq("i5_cmd",   command, 16'h1111);
      chk_eq("i5_pcout", pc_out,  16'hFFFF);
      @(negedge clk);
      chk_eq("wrap_req",  16'(imem_req), 16'd1);
      chk_eq("wrap_addr", imem_addr,     16'h0000);

      fetch(16'hC0F0, 0);
      chk_eq("hlt_cmd",   command,        16'hC0F0);
      chk_eq("hlt_pcout", pc_out,         16'h0000);
      chk_eq("hlt_valid", 16'(cmd_valid), 16'd1);
      @(negedge clk);
`ifdef HALT_DETECT_EN
      chk_eq("hlt_halted", 16'(halted),   16'd1);
      chk_eq("hlt_req",    16'(imem_req), 16'd0);
      pc_load = 1'b1; branch_target = 16'h0100;
      repeat (2) @(negedge clk);
      pc_load = 1'b0;
      chk_eq("hlt_frz_req",  16'(imem_req), 16'd0);
      chk_eq("hlt_frz_addr", imem_addr,     16'h0001);
      chk_eq("hlt_frz_cmd",  command,       16'hC0F0);
      chk_eq("hlt_frz_hlt",  16'(halted),   16'd1);
`else
      chk_eq("nohlt_halted", 16'(halted),   16'd0);
      chk_eq("nohlt_req",    16'(imem_req), 16'd1);
      chk_eq("nohlt_addr",   imem_addr,     16'h0001);
      @(negedge clk);
      chk_eq("nohlt_wait_req", 16'(imem_req), 16'd1);
`endif

      // Reset during an outstanding request; the late ack is ignored.
      reset = 1'b1;
      @(negedge clk);
      chk_reset_state("rst2");
      reset = 1'b0; imem_ack = 1'b1; imem_data = 16'h7777;
      @(negedge clk);
      imem_ack = 1'b0;
      chk_eq("rst2_req",  16'(imem_req),  16'd1);
      chk_eq("rst2_addr", imem_addr,      16'h0000);
      chk_eq("rst2_cmd",  command,        16'hC0E0);
      chk_eq("rst2_val",  16'(cmd_valid), 16'd0);
      fetch(16'h5555, 0);
      chk_eq("i6_cmd",   command,        16'h5555);
      chk_eq("i6_pcout", pc_out,         16'h0000);
      chk_eq("i6_bef",   before_command, 16'hC0E0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch_issue_unit.md
FETCH_ISSUE_UNIT -- requirements
Module: fetch_issue_unit

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port imem_req, output, 1, instruction-memory read request, held high until imem_ack.
REQ-004 SHALL have port imem_addr, output, 16, word address of the current fetch; equals pc whenever imem_req is high.
REQ-005 SHALL have port imem_ack, input, 1, one-cycle pulse: imem_data is valid this cycle.
REQ-006 SHALL have port imem_data, input, 16, fetched instruction word.
REQ-007 SHALL have port pc_load, input, 1, redirect request from the decode/execute stages.
REQ-008 SHALL have port branch_target, input, 16, new pc, sampled when pc_load=1.
REQ-009 SHALL have port stall, input, 1, downstream not ready; hold the issued instruction.
REQ-010 SHALL have ports command, before_command and two_before_command, outputs, 16 each, issued instruction, previous instruction and instruction before that; these drive the decoder's COMMAND, BeforeCOMMAND and TwoBeforeCOMMAND inputs.
REQ-011 SHALL have port cmd_valid, output, 1, command holds a newly issued or still-held real instruction.
REQ-012 SHALL have port pc_out, output, 16, address of command, for PC-relative branch arithmetic.
REQ-013 SHALL have port halted, output, 1, core has issued HLT.

Function
REQ-014 SHALL implement FSM states FETCH, WAIT, ISSUE, DROP and HALT.
REQ-015 FETCH SHALL assert imem_req with imem_addr=pc and go to WAIT in the next cycle; if imem_ack arrives in FETCH, it SHALL behave as in WAIT.
REQ-016 WAIT SHALL keep imem_req high; on imem_ack it SHALL register command<=imem_data, before<=command, two_before<=before, pc_out<=pc, pc<=pc+1, and enter ISSUE. Latency: command visible 1 cycle after ack.
REQ-017 pc increment SHALL be modulo 2^16 (16'hFFFF+1=16'h0000).
REQ-018 ISSUE with stall=0 SHALL drive cmd_valid=1 for that cycle and return to FETCH.
REQ-019 ISSUE with stall=1 SHALL hold command, both history registers, pc and cmd_valid unchanged, with imem_req=0.
REQ-020 pc_load=1 SHALL take priority over stall and ack. It SHALL set pc<=branch_target, command<=NOP, cmd_valid<=0 and shift the history (before<=command). It SHALL go to DROP if a request is outstanding (FETCH or WAIT without ack in that cycle); otherwise it SHALL go to FETCH.
REQ-021 DROP SHALL deassert imem_req, discard the data of the next imem_ack, then enter FETCH. An ack coinciding with pc_load SHALL be discarded, with the next state FETCH.
REQ-022 NOP SHALL be 16'hC0E0. Its function field 4'b1110 guarantees no register write and no forwarding match in the decoder.
REQ-023 HLT SHALL be any word with [15:14]=2'b11 and [7:4]=4'b1111. When it is issued, the unit SHALL enter HALT: imem_req=0, halted=1, outputs frozen, pc_load ignored, exit only by reset.

Reset
REQ-024 reset SHALL set pc=16'h0000, pc_out=16'h0000, command, before_command and two_before_command to NOP, cmd_valid=0, imem_req=0, halted=0 and state FETCH.
REQ-025 reset asserted mid-WAIT SHALL abandon the request. An ack in the first cycle after reset SHALL be ignored, because imem_req was low.

Configuration
REQ-026 Macro HALT_DETECT_EN SHALL compile in REQ-023.
REQ-027 Without HALT_DETECT_EN, HLT SHALL be issued as an ordinary instruction, halted SHALL be tied to 0 and the HALT state SHALL be absent.

Structure
REQ-028 The shared package simple_arch_pkg SHALL hold the NOP constant, the HLT opcode and function field values, the state enum and the instruction field index constants.
REQ-029 The three-deep history shift register SHALL be sub-module cmd_history, with ports clk, reset, shift, flush and din, and outputs for the three stages.

Verification
REQ-030 Reset, then memory returning 16'h8101 and 16'h8202 with 1-cycle ack -> command=8101, pc_out=0000; next issue gives command=8202, before=8101, two_before=C0E0.
REQ-031 stall=1 for 3 cycles during ISSUE of 16'hC120 -> command, pc and cmd_valid constant, imem_req=0 throughout; the next fetch address is unchanged.
REQ-032 pc_load=1, branch_target=16'h0040 during WAIT with ack 2 cycles later -> that data is discarded; the next imem_addr is 0040; command is C0E0 with cmd_valid=0 until the refetch.
REQ-033 pc=16'hFFFF fetch -> next imem_addr is 16'h0000.
REQ-034 Issue 16'hC0F0 with HALT_DETECT_EN -> halted=1, imem_req stays 0, pc_load ignored; without the macro -> fetching continues at pc+1.
REQ-035 Simultaneous stall=1 and pc_load=1 in ISSUE -> redirect wins: command=C0E0, the next imem_addr equals branch_target.
